// File: rtl/mc6845_bus_sequencer.sv
// Host-side MC6845 CRTC register-port sequencer: every register write is an
// address-register phase followed by a data phase, sourced from a latched table or the host port.
module mc6845_bus_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int E_HIGH   = 2,
  parameter int E_LOW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_REGS*8-1:0] cfg,
  input  logic                  wr_req,
  input  logic [4:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  csn,
  output logic                  e,
  output logic                  rs,
  output logic                  rw,
  output logic [7:0]            d_out,
  output logic                  d_oe
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA_HI,
    DATA_LO,
    GAP
  } state_t;

  localparam int TMAX = (E_HIGH > E_LOW) ? E_HIGH : E_LOW;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_HI = TW'(E_HIGH - 1);
  localparam logic [TW-1:0] T_LO = TW'(E_LOW - 1);
  localparam logic [4:0]    LAST = 5'(NUM_REGS - 1);

  state_t                state;
  logic [TW-1:0]         tmr;
  logic [4:0]            idx;
  logic                  seq;
  logic [NUM_REGS*8-1:0] tbl;
  logic [7:0]            hdata;
  logic [7:0]            cur_val;

  assign cur_val = 8'(tbl >> {idx, 3'b000});

  // The address value sits in d_out through both ADDR phases, so only the host data needs a holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      idx    <= '0;
      seq    <= 1'b0;
      tbl    <= '0;
      hdata  <= '0;
      csn    <= 1'b1;
      e      <= 1'b0;
      rs     <= 1'b0;
      rw     <= 1'b1;
      d_out  <= '0;
      d_oe   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || wr_req) begin
            state <= ADDR_HI;
            tmr   <= T_HI;
            idx   <= '0;
            csn   <= 1'b0;
            e     <= 1'b1;
            rs    <= 1'b0;
            rw    <= 1'b0;
            d_oe  <= 1'b1;
            busy  <= 1'b1;
            if (start) begin
              seq   <= 1'b1;
              tbl   <= cfg;
              d_out <= 8'h00;
            end else begin
              seq   <= 1'b0;
              hdata <= wr_data;
              d_out <= {3'b000, wr_addr};
            end
          end
        end

        ADDR_HI: begin
          if (tmr == '0) begin
            state <= ADDR_LO;
            tmr   <= T_LO;
            e     <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        ADDR_LO: begin
          if (tmr == '0) begin
            state <= DATA_HI;
            tmr   <= T_HI;
            e     <= 1'b1;
            rs    <= 1'b1;
            d_out <= seq ? cur_val : hdata;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        DATA_HI: begin
          if (tmr == '0) begin
            state <= DATA_LO;
            tmr   <= T_LO;
            e     <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        DATA_LO: begin
          if (tmr == '0) begin
            state  <= GAP;
            csn    <= 1'b1;
            rs     <= 1'b0;
            rw     <= 1'b1;
            d_oe   <= 1'b0;
            d_out  <= 8'h00;
            wr_ack <= !seq;
            done   <= seq && (idx == LAST);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        GAP: begin
          // A sequence chains straight into the next index; anything else goes through IDLE.
          if (seq && (idx != LAST)) begin
            state <= ADDR_HI;
            tmr   <= T_HI;
            idx   <= idx + 5'd1;
            csn   <= 1'b0;
            e     <= 1'b1;
            rw    <= 1'b0;
            d_oe  <= 1'b1;
            d_out <= {3'b000, idx + 5'd1};
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            seq   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc6845_bus_sequencer.sv
// Directed bench for mc6845_bus_sequencer with an attached CRTC register model
// that checks every completed register write against a scoreboard queue.
module tb_mc6845_bus_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cfg;
  logic         wr_req;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_ack;
  logic         busy;
  logic         done;
  logic         csn;
  logic         e;
  logic         rs;
  logic         rw;
  logic [7:0]   d_out;
  logic         d_oe;

  int total;
  int bad;
  int writes;
  int dones;

  logic [15:0] sb [$];
  logic [7:0]  crtc_addr;
  logic [7:0]  crtc_reg [32];
  logic        e_prev;

  mc6845_bus_sequencer #(.NUM_REGS(16), .E_HIGH(2), .E_LOW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cfg     (cfg),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .busy    (busy),
    .done    (done),
    .csn     (csn),
    .e       (e),
    .rs      (rs),
    .rw      (rw),
    .d_out   (d_out),
    .d_oe    (d_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [4:0] a, input logic [7:0] d);
    start   = s;
    wr_req  = w;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic setCfg(input logic [7:0] base);
    for (int n = 0; n < 16; n++) cfg[n*8 +: 8] = base + 8'(n);
  endtask

  task automatic pushSeq(input logic [7:0] base, input int count);
    for (int n = 0; n < count; n++) sb.push_back({8'(n), base + 8'(n)});
  endtask

  function automatic logic [15:0] outVec();
    return {csn, e, rs, rw, d_oe, busy, done, wr_ack, d_out};
  endfunction

  function automatic logic [15:0] expVec(input logic c, input logic ee, input logic r, input logic w,
                                         input logic oe, input logic b, input logic dn, input logic ak,
                                         input logic [7:0] dv);
    return {c, ee, r, w, oe, b, dn, ak, dv};
  endfunction

  // Expected bus state for cycle k (1..9) of a single host write.
  function automatic logic [15:0] hostExp(input int k, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dv;
    dv = (k <= 4) ? a : ((k <= 8) ? d : 8'h00);
    return expVec(k == 9, (k == 1) || (k == 2) || (k == 5) || (k == 6), (k >= 5) && (k <= 8),
                  k == 9, k < 9, 1'b1, 1'b0, k == 9, dv);
  endfunction

  // CRTC model: latches on the E falling edge while selected for a write.
  always @(negedge clk) begin
    if (e_prev && !e && !csn && !rw) begin
      if (!rs) begin
        crtc_addr = d_out;
      end else begin
        crtc_reg[crtc_addr[4:0]] = d_out;
        writes++;
        checkOutput("write_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) checkOutput("write_addr_data", {crtc_addr, d_out}, sb.pop_front());
      end
    end
    e_prev = e;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0; bad = 0; writes = 0; dones = 0;
    rst_n = 1'b1; cfg = '0; e_prev = 1'b0; crtc_addr = 8'h00;
    for (int i = 0; i < 32; i++) crtc_reg[i] = 8'h00;
    applyStimulus(0, 0, 5'd0, 8'h00);

    // Asynchronous reset mid-cycle with START held
    #3 rst_n = 1'b0; start = 1'b1;
    #1 checkOutput("reset_async", outVec(), 32'h9000);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_hold_start", outVec(), 32'h9000);
    end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); checkOutput("idle_after_reset", outVec(), 32'h9000);

    // Host single write R1 = 0x5E
    $display("[TB] host write");
    sb.push_back({8'h01, 8'h5E});
    applyStimulus(0, 1, 5'd1, 8'h5E);
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hostwr_c%0d", k), outVec(), hostExp(k, 8'h01, 8'h5E));
      if (k == 9) applyStimulus(0, 0, 5'd0, 8'h00);
    end
    @(negedge clk);
    checkOutput("hostwr_idle", outVec(), 32'h9000);
    checkOutput("hostwr_r1", crtc_reg[1], 8'h5E);
    checkOutput("hostwr_sb_empty", sb.size(), 0);

    // Full sequence, CFG changed at cycle 20
    $display("[TB] full sequence");
    setCfg(8'h10); pushSeq(8'h10, 16);
    applyStimulus(1, 0, 5'd0, 8'h00);
    @(posedge clk);
    for (int k = 1; k <= 145; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(0, 0, 5'd0, 8'h00);
      if (k == 20) setCfg(8'hA0);
      if (k <= 144) checkOutput($sformatf("seq_busy_done_c%0d", k), {busy, done}, {1'b1, k == 144});
      else checkOutput("seq_end_idle", outVec(), 32'h9000);
    end
    checkOutput("seq_r15", crtc_reg[15], 8'h1F);
    checkOutput("seq_sb_empty", sb.size(), 0);

    // START and WR_REQ together: sequence first, host write after
    $display("[TB] simultaneous requests");
    setCfg(8'h20); pushSeq(8'h20, 16); sb.push_back({8'd12, 8'h34});
    applyStimulus(1, 1, 5'd12, 8'h34);
    @(posedge clk);
    for (int k = 1; k <= 156; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(0, 1, 5'd12, 8'h34);
      checkOutput($sformatf("simul_done_ack_c%0d", k), {done, wr_ack}, {k == 144, k == 154});
      if (k == 154) applyStimulus(0, 0, 5'd0, 8'h00);
    end
    checkOutput("simul_idle", outVec(), 32'h9000);
    checkOutput("simul_r12", crtc_reg[12], 8'h34);
    checkOutput("simul_sb_empty", sb.size(), 0);

    // START pulsed at cycle 50 of a running sequence is ignored
    $display("[TB] start while busy");
    setCfg(8'h30); pushSeq(8'h30, 16);
    writes = 0; dones = 0;
    applyStimulus(1, 0, 5'd0, 8'h00);
    @(posedge clk);
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (k == 50) applyStimulus(1, 0, 5'd0, 8'h00);
      else if ((k == 1) || (k == 51)) applyStimulus(0, 0, 5'd0, 8'h00);
    end
    checkOutput("busy_start_dones", dones, 1);
    checkOutput("busy_start_writes", writes, 16);
    checkOutput("busy_start_idle", outVec(), 32'h9000);
    checkOutput("busy_start_sb_empty", sb.size(), 0);

    // Reset during DATA_HI of R5, then restart from R0
    $display("[TB] reset mid-write");
    setCfg(8'h40); pushSeq(8'h40, 5);
    applyStimulus(1, 0, 5'd0, 8'h00);
    @(posedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(0, 0, 5'd0, 8'h00);
    end
    checkOutput("rstmid_data_hi_r5", outVec(), expVec(0, 1, 1, 0, 1, 1, 0, 0, 8'h45));
    #2 rst_n = 1'b0;
    #1 checkOutput("rstmid_csn_doe", {csn, d_oe}, 2'b10);
    checkOutput("rstmid_idle", outVec(), 32'h9000);
    @(negedge clk); rst_n = 1'b1;
    checkOutput("rstmid_sb_empty", sb.size(), 0);
    @(negedge clk);
    setCfg(8'h50); pushSeq(8'h50, 16);
    applyStimulus(1, 0, 5'd0, 8'h00);
    @(posedge clk);
    for (int k = 1; k <= 145; k++) begin
      @(negedge clk);
      if (k == 1) begin
        applyStimulus(0, 0, 5'd0, 8'h00);
        checkOutput("restart_c1", outVec(), expVec(0, 1, 0, 0, 1, 1, 0, 0, 8'h00));
      end
      if (k <= 144) checkOutput($sformatf("restart_busy_done_c%0d", k), {busy, done}, {1'b1, k == 144});
      else checkOutput("restart_idle", outVec(), 32'h9000);
    end
    checkOutput("restart_r0", crtc_reg[0], 8'h50);
    checkOutput("restart_r5", crtc_reg[5], 8'h55);
    checkOutput("restart_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
